// File: rtl/display_ram_writer_if.sv
// Bundle of the display RAM writer's stream inputs and RAM-side outputs.
// master = the datapath/bench that drives the streams, slave = the writer.
interface display_ram_writer_if;
    logic        freeze;
    logic        sampleValid;
    logic [7:0]  sampleTime;
    logic        magValid;
    logic [9:0]  magIndex;
    logic [15:0] magData;
    logic        enaTime;
    logic        weaTime;
    logic [9:0]  addraTime;
    logic [7:0]  dinaTime;
    logic        weaFreq;
    logic [9:0]  addraFreq;
    logic [7:0]  dinaFreq;
    logic        trigAuto;
    logic        frameDone;

    modport master (
        output freeze, sampleValid, sampleTime, magValid, magIndex, magData,
        input  enaTime, weaTime, addraTime, dinaTime,
        input  weaFreq, addraFreq, dinaFreq, trigAuto, frameDone
    );

    modport slave (
        input  freeze, sampleValid, sampleTime, magValid, magIndex, magData,
        output enaTime, weaTime, addraTime, dinaTime,
        output weaFreq, addraFreq, dinaFreq, trigAuto, frameDone
    );
endinterface

// File: rtl/display_ram_writer.sv
// Write-side producer for the time and frequency display RAMs.
// Time path: triggered (or timed-out) 640-sample capture with clamping.
// Freq path: shift/saturate FFT magnitudes into bar heights for the low bins.
module display_ram_writer #(
    parameter int TIME_LEN     = 640,
    parameter int FREQ_BINS    = 100,
    parameter int MAG_SHIFT    = 8,
    parameter int TIME_CLAMP   = 120,
    parameter int TRIG_TIMEOUT = 2048,
    parameter int HOLDOFF      = 4096
) (
    input  logic                 ck100MHz,
    input  logic                 rst,
    display_ram_writer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_WAIT_TRIG, S_CAPTURE, S_HOLDOFF
    } state_t;

    localparam logic signed [8:0] CLAMP_HI = 9'(TIME_CLAMP);
    localparam logic signed [8:0] CLAMP_LO = -CLAMP_HI;

    state_t      state_q;
    logic [12:0] cnt_q;          // timeout count in WAIT_TRIG, holdoff count in HOLDOFF
    logic [9:0]  addr_n_q;       // next capture address
    logic [7:0]  prev_q;         // previous accepted sample
    logic        ena_time_q;
    logic [9:0]  addra_time_q;
    logic [7:0]  dina_time_q;
    logic        trig_auto_q;
    logic        done_pend_q;
    logic        frame_done_q;

    logic        wea_freq_q, wea_freq_d;
    logic [9:0]  addra_freq_q, addra_freq_d;
    logic [7:0]  dina_freq_q, dina_freq_d;

    logic signed [8:0] samp9;
    logic [7:0]        clamped;
    logic              is_trigger;
    logic [15:0]       mag_shifted;

    assign samp9      = $signed({bus.sampleTime[7], bus.sampleTime});
    assign is_trigger = prev_q[7] && !bus.sampleTime[7];
    assign mag_shifted = bus.magData >> MAG_SHIFT;

    // Clamp the incoming sample to the displayable range.
    always_comb begin
        clamped = bus.sampleTime;
        if (samp9 > CLAMP_HI)
            clamped = CLAMP_HI[7:0];
        else if (samp9 < CLAMP_LO)
            clamped = CLAMP_LO[7:0];
    end

    // Time capture FSM with registered RAM-port outputs.
    always_ff @(posedge ck100MHz) begin
        if (rst) begin
            state_q      <= S_ARM;
            cnt_q        <= '0;
            addr_n_q     <= '0;
            prev_q       <= '0;
            ena_time_q   <= 1'b0;
            addra_time_q <= '0;
            dina_time_q  <= '0;
            trig_auto_q  <= 1'b0;
            done_pend_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            ena_time_q   <= 1'b0;
            done_pend_q  <= 1'b0;
            frame_done_q <= done_pend_q;
            if (bus.sampleValid)
                prev_q <= bus.sampleTime;
            case (state_q)
                S_IDLE: begin
                    if (!bus.freeze)
                        state_q <= S_ARM;
                end
                S_ARM: begin
                    cnt_q <= '0;
                    if (bus.freeze)
                        state_q <= S_IDLE;
                    else if (bus.sampleValid)
                        state_q <= S_WAIT_TRIG;
                end
                S_WAIT_TRIG: begin
                    if (bus.freeze) begin
                        state_q <= S_IDLE;
                    end else if (bus.sampleValid) begin
                        if (is_trigger || cnt_q == 13'(TRIG_TIMEOUT - 1)) begin
                            state_q      <= S_CAPTURE;
                            ena_time_q   <= 1'b1;
                            addra_time_q <= '0;
                            dina_time_q  <= clamped;
                            addr_n_q     <= 10'd1;
                            trig_auto_q  <= !is_trigger;
                        end else begin
                            cnt_q <= cnt_q + 13'd1;
                        end
                    end
                end
                S_CAPTURE: begin
                    // freeze is honoured only once the frame is complete
                    if (bus.sampleValid) begin
                        ena_time_q   <= 1'b1;
                        addra_time_q <= addr_n_q;
                        dina_time_q  <= clamped;
                        if (addr_n_q == 10'(TIME_LEN - 1)) begin
                            done_pend_q <= 1'b1;
                            cnt_q       <= '0;
                            state_q     <= bus.freeze ? S_IDLE : S_HOLDOFF;
                        end else begin
                            addr_n_q <= addr_n_q + 10'd1;
                        end
                    end
                end
                S_HOLDOFF: begin
                    if (bus.freeze) begin
                        state_q <= S_IDLE;
                    end else if (bus.sampleValid) begin
                        if (cnt_q == 13'(HOLDOFF - 1))
                            state_q <= S_ARM;
                        else
                            cnt_q <= cnt_q + 13'd1;
                    end
                end
                default: state_q <= S_ARM;
            endcase
        end
    end

    // Next-state of the frequency write port; address/data hold between writes.
    always_comb begin
        wea_freq_d   = 1'b0;
        addra_freq_d = addra_freq_q;
        dina_freq_d  = dina_freq_q;
        if (bus.magValid && bus.magIndex < 10'(FREQ_BINS)) begin
            wea_freq_d   = 1'b1;
            addra_freq_d = bus.magIndex;
            dina_freq_d  = (|mag_shifted[15:8]) ? 8'hFF : mag_shifted[7:0];
        end
    end

    // Frequency write port registers.
    always_ff @(posedge ck100MHz) begin
        if (rst) begin
            wea_freq_q   <= 1'b0;
            addra_freq_q <= '0;
            dina_freq_q  <= '0;
        end else begin
            wea_freq_q   <= wea_freq_d;
            addra_freq_q <= addra_freq_d;
            dina_freq_q  <= dina_freq_d;
        end
    end

    assign bus.enaTime   = ena_time_q;
    assign bus.weaTime   = ena_time_q;
    assign bus.addraTime = addra_time_q;
    assign bus.dinaTime  = dina_time_q;
    assign bus.weaFreq   = wea_freq_q;
    assign bus.addraFreq = addra_freq_q;
    assign bus.dinaFreq  = dina_freq_q;
    assign bus.trigAuto  = trig_auto_q;
    assign bus.frameDone = frame_done_q;
endmodule
